// File: rtl/regfile_wb_queue_if.sv
// Write-back queue channel bundle: push side, register file write port and forwarding lookup.
// The queue takes the slave view, the write-back/decode/register-file side takes the master view.
interface regfile_wb_queue_if #(
  parameter int N = 6,
  parameter int M = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_addr;
  logic [M-1:0] in_data;
  logic         drain_en;
  logic [N-1:0] A3;
  logic [M-1:0] WD3;
  logic         WE3;
  logic [N-1:0] fwd_addr;
  logic         fwd_hit;
  logic [M-1:0] fwd_data;

  modport master (
    output in_valid, in_addr, in_data, drain_en, fwd_addr,
    input  in_ready, A3, WD3, WE3, fwd_hit, fwd_data
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_en, fwd_addr,
    output in_ready, A3, WD3, WE3, fwd_hit, fwd_data
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue with youngest-match forwarding; push-to-commit 1 cycle, in_ready = !full.
// Optional WBQ_COALESCE_EN merges a push into the youngest matching pending entry.
module regfile_wb_queue #(
  parameter int N     = 6,
  parameter int M     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  regfile_wb_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]    addr_q [DEPTH];
  logic [M-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]   head, tail;
  logic [AW:0]     count_q;

  logic            push, pop, push_alloc, push_coal;
  logic [AW-1:0]   coal_idx;
  logic [AW-1:0]   fidx;
  logic            fwd_hit_c;
  logic [M-1:0]    fwd_data_c;

  assign empty        = (count_q == '0);
  assign full         = (count_q == (AW+1)'(DEPTH));
  assign count        = count_q;
  assign bus.in_ready = !full;
  assign bus.WE3      = !empty && bus.drain_en && !flush;
  assign bus.A3       = addr_q[head];
  assign bus.WD3      = data_q[head];

  assign pop  = bus.WE3;
  assign push = bus.in_valid && !full && !flush;

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fidx       = head;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = head + AW'(i);
      if (vld_q[fidx] && addr_q[fidx] == bus.fwd_addr) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = data_q[fidx];
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit_c;
  assign bus.fwd_data = fwd_data_c;

`ifdef WBQ_COALESCE_EN
  logic          coal_hit;
  logic [AW-1:0] cidx;

  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    cidx     = head;
    for (int i = 0; i < DEPTH; i++) begin
      cidx = head + AW'(i);
      if (vld_q[cidx] && addr_q[cidx] == bus.in_addr) begin
        coal_hit = 1'b1;
        coal_idx = cidx;
      end
    end
  end

  // A match that is leaving this cycle cannot absorb the write; allocate instead.
  assign push_coal = push && coal_hit && !(pop && coal_idx == head);
`else
  assign coal_idx  = '0;
  assign push_coal = 1'b0;
`endif

  assign push_alloc = push && !push_coal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      vld_q   <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      vld_q   <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push_alloc) begin
        addr_q[tail] <= bus.in_addr;
        data_q[tail] <= bus.in_data;
        vld_q[tail]  <= 1'b1;
        tail         <= tail + 1'b1;
      end
      if (push_coal) begin
        data_q[coal_idx] <= bus.in_data;
      end
      case ({push_alloc, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue; expectations are hand-computed per step.
module tb_regfile_wb_queue;
  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;
  logic       full, empty;
  int         checks;
  int         failures;
  int         we_seen;

  regfile_wb_queue_if #(.N(6), .M(32)) bus ();

  regfile_wb_queue #(.N(6), .M(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Move just past the next rising edge; inputs set afterwards stay clear of it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] a, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    we_seen  = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    drive(1'b0, 6'd0, 32'h0);
    bus.drain_en = 1'b1;
    bus.fwd_addr = 6'd0;

    // Reset state
    cyc(); cyc();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_we3", 32'(bus.WE3), 32'd0);
    chk("rst_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    chk("rst_fwd_data", bus.fwd_data, 32'h0);
    chk("rst_a3", 32'(bus.A3), 32'd0);
    chk("rst_wd3", bus.WD3, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;

    // Single push, drained the very next cycle
    drive(1'b1, 6'd3, 32'hA5A5A5A5);
    settle();
    chk("t1_we3_pre", 32'(bus.WE3), 32'd0);
    cyc();
    drive(1'b0, 6'd0, 32'h0);
    bus.fwd_addr = 6'd3;
    settle();
    chk("t1_we3", 32'(bus.WE3), 32'd1);
    chk("t1_a3", 32'(bus.A3), 32'd3);
    chk("t1_wd3", bus.WD3, 32'hA5A5A5A5);
    chk("t1_count1", 32'(count), 32'd1);
    chk("t1_fwd_popping", 32'(bus.fwd_hit), 32'd1);
    cyc();
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_we3_post", 32'(bus.WE3), 32'd0);

    // Fill to full, reject fifth push, drain in order across the wrap
    bus.drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 6'(i), 32'h100 + 32'(i));
      cyc();
    end
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 6'd9, 32'h999);
    cyc();
    drive(1'b0, 6'd0, 32'h0);
    bus.fwd_addr = 6'd9;
    settle();
    chk("t2_count_after_5th", 32'(count), 32'd4);
    chk("t2_fwd_rejected", 32'(bus.fwd_hit), 32'd0);
    bus.drain_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("t2_we3", 32'(bus.WE3), 32'd1);
      chk("t2_a3", 32'(bus.A3), 32'(i));
      chk("t2_wd3", bus.WD3, 32'h100 + 32'(i));
      cyc();
    end
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_we3_post", 32'(bus.WE3), 32'd0);

    // Same-address pair: youngest forwards
    bus.drain_en = 1'b0;
    drive(1'b1, 6'd5, 32'h11);
    cyc();
    drive(1'b1, 6'd5, 32'h22);
    cyc();
    drive(1'b0, 6'd0, 32'h0);
    bus.fwd_addr = 6'd5;
    settle();
    chk("t3_fwd_hit", 32'(bus.fwd_hit), 32'd1);
    chk("t3_fwd_data", bus.fwd_data, 32'h22);
    bus.fwd_addr = 6'd6;
    settle();
    chk("t3_miss_hit", 32'(bus.fwd_hit), 32'd0);
    chk("t3_miss_data", bus.fwd_data, 32'h0);
    bus.drain_en = 1'b1;
`ifdef WBQ_COALESCE_EN
    chk("t3_count", 32'(count), 32'd1);
    settle();
    chk("t3_wd3_only", bus.WD3, 32'h22);
    cyc();
`else
    chk("t3_count", 32'(count), 32'd2);
    settle();
    chk("t3_wd3_first", bus.WD3, 32'h11);
    cyc();
    chk("t3_wd3_second", bus.WD3, 32'h22);
    cyc();
`endif
    chk("t3_empty", 32'(empty), 32'd1);

    // Flush with 3 pending and a colliding push
    bus.drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd10 + 6'(i), 32'h300 + 32'(i));
      cyc();
    end
    chk("t4_count3", 32'(count), 32'd3);
    flush = 1'b1;
    bus.drain_en = 1'b1;
    drive(1'b1, 6'd13, 32'h313);
    settle();
    chk("t4_we3_flush", 32'(bus.WE3), 32'd0);
    cyc();
    flush = 1'b0;
    bus.drain_en = 1'b0;
    drive(1'b0, 6'd0, 32'h0);
    bus.fwd_addr = 6'd13;
    settle();
    chk("t4_count0", 32'(count), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_push_dropped", 32'(bus.fwd_hit), 32'd0);

    // Ten cycles of simultaneous push and pop at count 2
    drive(1'b1, 6'd20, 32'h200);
    cyc();
    drive(1'b1, 6'd21, 32'h201);
    cyc();
    bus.drain_en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, 6'd22 + 6'(j), 32'h202 + 32'(j));
      settle();
      chk("t5_count", 32'(count), 32'd2);
      chk("t5_wd3", bus.WD3, 32'h200 + 32'(j));
      cyc();
    end
    drive(1'b0, 6'd0, 32'h0);
    settle();
    chk("t5_tail0", bus.WD3, 32'h20A);
    cyc();
    chk("t5_tail1", bus.WD3, 32'h20B);
    cyc();
    chk("t5_empty", 32'(empty), 32'd1);

    // Reset mid-drain with 3 pending
    bus.drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd40 + 6'(i), 32'h400 + 32'(i));
      cyc();
    end
    drive(1'b0, 6'd0, 32'h0);
    bus.drain_en = 1'b1;
    settle();
    chk("t6_a3_first", 32'(bus.A3), 32'd40);
    cyc();
    rst_n = 1'b0;
    settle();
    chk("t6_we3_rst", 32'(bus.WE3), 32'd0);
    chk("t6_empty_rst", 32'(empty), 32'd1);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (bus.WE3 === 1'b1) we_seen++;
      cyc();
    end
    chk("t6_no_writes", 32'(we_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue sitting between the pipeline's write-back stage and the register file write port (`A3`/`WD3`/`WE3`). It buffers register write requests in an in-order FIFO and drains at most one per cycle into the register file whenever the write port is granted. It also forwards pending, not-yet-committed data to a read-side lookup port so decode sees the newest value of a register.

## Interface
- `N`, 6: register address width; matches the register file address width.
- `M`, 32: data width.
- `DEPTH`, 4: queue entries; power of 2, at least 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous; discards all pending entries.
- `in_valid`  in  1  write request present.
- `in_ready`  out  1  equals `!full`.
- `in_addr`  in  N  destination register.
- `in_data`  in  M  write data.
- `drain_en`  in  1  register file write port is granted this cycle.
- `A3`  out  N  head entry address.
- `WD3`  out  M  head entry data.
- `WE3`  out  1  equals `!empty && drain_en && !flush`.
- `fwd_addr`  in  N  lookup address from decode.
- `fwd_hit`  out  1  a valid entry matches `fwd_addr`.
- `fwd_data`  out  M  data of the youngest matching entry; 0 when there is no hit.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `full`, `empty`  out  1  `count==DEPTH` and `count==0`, respectively.

## Operation
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, a per-entry valid bit, and a count register.
- Push: occurs when `in_valid && in_ready && !flush`. The entry is written at the tail and the tail advances.
- Pop: occurs when `WE3` is 1. The head advances at the same edge the register file captures `A3`/`WD3`.
- Push and pop in the same cycle: both take effect and `count` is unchanged.
- Full: `in_ready=0`. There is no same-cycle bypass, even if a pop happens that cycle.
- Empty: `WE3=0`. `A3`/`WD3` hold the previous head slot contents, which are don't-care.
- Flush: takes priority over push and pop. It clears all valid bits, sets head=tail=0 and `count=0`, and forces `WE3=0` that cycle.
- Forwarding: purely combinational over all valid entries. It is priority-encoded from the tail backward so the youngest matching entry wins.
- Forwarding is not affected by a same-cycle push, because the incoming request is not yet an entry.
- An entry being popped this cycle still forwards this cycle.
- Ordering: entries drain strictly in push order. Two writes to the same address commit oldest first.
- Address 0 receives no special treatment.

## Timing
- Reset (asynchronous assert, synchronous release): head=tail=0 and `count=0`.
  - Outputs after reset: `empty=1`, `full=0`, `in_ready=1`, `WE3=0`, `fwd_hit=0`, `fwd_data=0`.
  - `A3` and `WD3` reset to 0 because the storage array is cleared.
- Asserting reset mid-operation drops pending entries. Nothing is written to the register file after assertion.
- Latency: a request pushed at edge k can drive `WE3=1` in cycle k+1, at the earliest, with the register file write at edge k+1.
- Sustained throughput: one push and one pop per cycle while `drain_en=1`.
- `in_ready`, `full`, `empty` and `count` are register-derived and carry no combinational path from `in_valid`.
- `WE3` depends combinationally only on `drain_en`, `flush` and state.

## Configuration
- `WBQ_COALESCE_EN` defined:
  - A push whose `in_addr` matches a valid entry overwrites the data of the youngest matching entry in place. No entry is allocated and the tail does not move.
  - If that matching entry is the head being popped in the same cycle, the push allocates normally instead.
  - `in_ready` stays `!full`.
- Undefined: every push allocates a new entry.

## Test plan
- Reset, then push addr 3 / data 0xA5A5A5A5 with `drain_en=1`:
  - `WE3=1` with `A3=3`, `WD3=0xA5A5A5A5` on the next cycle only.
  - `count` goes 0→1→0.
- With `drain_en=0`, push addresses 1, 2, 3, 4:
  - `full=1` and `in_ready=0`; a fifth push is not accepted.
  - Then set `drain_en=1`: pops occur in order 1, 2, 3, 4 across four cycles, covering pointer wrap.
- Push addr 5 / data 0x11, then addr 5 / data 0x22, with `fwd_addr=5`:
  - `fwd_hit=1`, `fwd_data=0x22`.
  - Without the macro: `count=2` and the drain commits 0x11 then 0x22.
  - With `WBQ_COALESCE_EN`: `count=1` and only 0x22 commits.
- Fill the queue to 3 entries, then `flush=1` for one cycle:
  - `WE3=0` during the flush cycle.
  - `count=0` and `empty=1` the next cycle.
  - A same-cycle push is dropped.
- Push and pop simultaneously for 10 cycles at `count=2`: `count` stays 2 and the data drains in order.
- Drop `rst_n` mid-drain with 3 entries pending:
  - `WE3=0` and `empty=1` immediately.
  - No further writes after release.
